// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port: req/addr held until ack; rdata valid with ack.
// Latency set by the memory; no backpressure beyond holding req until ack.
interface instr_fetch_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch unit: PC address -> memory read -> instruction; fetch_start to instr_valid is 1 + memory wait cycles.
// Backpressure: fetch_start is only accepted in IDLE; mem_req is held until mem_ack or timeout abort.
module instr_fetch_unit #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 16,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR      = DATA_WIDTH'(32'h00000013)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_start,
  input  logic [DATA_WIDTH-1:0] fetch_addr,
  input  logic                  fetch_addr_valid,
  input  logic                  flush,
  input  logic                  fault_clear,
  instr_fetch_unit_if.master    mem,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic                  instr_valid,
  output logic                  fetch_busy,
  output logic                  fetch_fault,
  output logic [1:0]            fault_cause
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic                  discard_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic                  fault_q;
  logic [1:0]            cause_q;

  logic load_addr;
  logic capture;
  logic timeout;
  logic misalign;
  logic resp_upd;
  logic req_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_addr = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    misalign  = 1'b0;
    resp_upd  = 1'b0;
    req_on    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fetch_start) begin
          if (!fetch_addr_valid || (fetch_addr[1:0] != 2'b00)) begin
            misalign = 1'b1;
          end else begin
            load_addr = 1'b1;
            state_d   = REQ;
          end
        end
      end
      REQ: begin
        req_on = 1'b1;
        if (mem.mem_ack) begin
          capture = 1'b1;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      RESP: begin
        // A flush landing in the response cycle still kills the update.
        resp_upd = !discard_q && !flush;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      discard_q <= 1'b0;
      addr_q    <= '0;
      rdata_q   <= '0;
      instr_q   <= NOP_INSTR;
    end else begin
      if (load_addr) begin
        addr_q <= {fetch_addr[DATA_WIDTH-1:2], 2'b00};
        cnt_q  <= '0;
      end else if (state_q == REQ && !mem.mem_ack) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (capture) begin
        rdata_q <= mem.mem_rdata;
      end

      // Discard is armed by any flush during REQ, including the ack cycle.
      if (state_q == REQ) begin
        if (timeout) begin
          discard_q <= 1'b0;
        end else if (flush) begin
          discard_q <= 1'b1;
        end
      end else if (state_q == RESP) begin
        discard_q <= 1'b0;
      end

      if (resp_upd) begin
        instr_q <= rdata_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else if (misalign) begin
      fault_q <= 1'b1;
      cause_q <= CAUSE_MISALIGN;
    end else if (timeout) begin
      fault_q <= 1'b1;
      cause_q <= CAUSE_TIMEOUT;
    end else if (fault_clear) begin
      fault_q <= 1'b0;
      cause_q <= CAUSE_NONE;
    end
  end

  assign mem.mem_req  = req_on;
  assign mem.mem_addr = addr_q;

  // Fresh data is forwarded during the valid pulse so instr_out matches instr_valid.
  assign instr_out   = resp_upd ? rdata_q : instr_q;
  assign instr_valid = resp_upd;
  assign fetch_busy  = (state_q != IDLE);
  assign fetch_fault = fault_q;
  assign fault_cause = cause_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; a negedge monitor scores every instr_valid pulse.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_start = 1'b0;
  logic [31:0] fetch_addr = 32'h0;
  logic        fetch_addr_valid = 1'b0;
  logic        flush = 1'b0;
  logic        fault_clear = 1'b0;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        fetch_busy;
  logic        fetch_fault;
  logic [1:0]  fault_cause;

  instr_fetch_unit_if #(.DATA_WIDTH(32)) mem_if ();

  instr_fetch_unit #(
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(16),
    .NOP_INSTR     (NOP)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_start     (fetch_start),
    .fetch_addr      (fetch_addr),
    .fetch_addr_valid(fetch_addr_valid),
    .flush           (flush),
    .fault_clear     (fault_clear),
    .mem             (mem_if),
    .instr_out       (instr_out),
    .instr_valid     (instr_valid),
    .fetch_busy      (fetch_busy),
    .fetch_fault     (fetch_fault),
    .fault_cause     (fault_cause)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  always @(negedge clk) begin
    if (rst_n && instr_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: instr_out=%h at cycle %0d, no fetch outstanding", instr_out, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (instr_out !== mon_e.data || cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL instr_result: got %h at cycle %0d, want %h at cycle %0d",
                   instr_out, cyc, mon_e.data, mon_e.cyc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered and left 1 time unit after a rising edge with the DUT in IDLE.
  task automatic fetch(input logic [31:0] addr, input int wait_n, input logic [31:0] data,
                       input int flush_at, input bit expect_ok);
    int n;
    fetch_start      = 1'b1;
    fetch_addr       = addr;
    fetch_addr_valid = 1'b1;
    n = cyc;
    if (expect_ok) exp_q.push_back('{data, n + 1 + wait_n});
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < wait_n; i++) begin
      flush = (i == flush_at);
      if (i == wait_n - 1) begin
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = data;
      end
      @(negedge clk);
      chk("req_high", {31'b0, mem_if.mem_req}, 32'd1);
      chk("req_addr", mem_if.mem_addr, {addr[31:2], 2'b00});
      tick();
      flush            = 1'b0;
      mem_if.mem_ack   = 1'b0;
      mem_if.mem_rdata = 32'h0;
    end
    @(negedge clk);
    chk("req_drop", {31'b0, mem_if.mem_req}, 32'd0);
    chk("busy_resp", {31'b0, fetch_busy}, 32'd1);
    tick();
  endtask

  initial begin
    int n;
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = 32'h0;

    @(negedge clk);
    chk("rst_req", {31'b0, mem_if.mem_req}, 32'd0);
    chk("rst_addr", mem_if.mem_addr, 32'h0);
    chk("rst_instr", instr_out, NOP);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_cause", {30'b0, fault_cause}, 32'd0);
    chk("rst_busy", {31'b0, fetch_busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    fetch(32'h00000100, 1, 32'h00500093, -1, 1'b1);
    @(negedge clk);
    chk("hold_zero_wait", instr_out, 32'h00500093);
    tick();

    fetch(32'h00000204, 5, 32'hFE010113, -1, 1'b1);
    @(negedge clk);
    chk("hold_wait", instr_out, 32'hFE010113);
    chk("wait_no_fault", {31'b0, fetch_fault}, 32'd0);
    tick();

    fetch_start = 1'b1; fetch_addr = 32'h00000102; fetch_addr_valid = 1'b0;
    tick();
    fetch_start = 1'b0; fetch_addr_valid = 1'b1;
    @(negedge clk);
    chk("mis_req", {31'b0, mem_if.mem_req}, 32'd0);
    chk("mis_fault", {31'b0, fetch_fault}, 32'd1);
    chk("mis_cause", {30'b0, fault_cause}, 32'd1);
    chk("mis_busy", {31'b0, fetch_busy}, 32'd0);
    chk("mis_instr", instr_out, 32'hFE010113);
    tick();
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    @(negedge clk);
    chk("clr_fault", {31'b0, fetch_fault}, 32'd0);
    chk("clr_cause", {30'b0, fault_cause}, 32'd0);
    tick();

    fetch_start = 1'b1; fetch_addr = 32'h00000103; fault_clear = 1'b1;
    tick();
    fetch_start = 1'b0; fault_clear = 1'b0;
    @(negedge clk);
    chk("fault_beats_clr", {29'b0, fetch_fault, fault_cause}, 32'd5);
    chk("bad_low_bits_busy", {31'b0, fetch_busy}, 32'd0);
    tick();
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;

    fetch_start = 1'b1; fetch_addr = 32'h00000300;
    tick();
    fetch_start = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!mem_if.mem_req) break;
      n++;
      tick();
    end
    chk("tmo_req_cycles", n, 32'd16);
    chk("tmo_fault", {31'b0, fetch_fault}, 32'd1);
    chk("tmo_cause", {30'b0, fault_cause}, 32'd2);
    chk("tmo_busy", {31'b0, fetch_busy}, 32'd0);
    tick();
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h12345678;
    tick();
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 32'h0;
    @(negedge clk);
    chk("late_ack_valid", {31'b0, instr_valid}, 32'd0);
    chk("late_ack_instr", instr_out, 32'hFE010113);
    chk("late_ack_busy", {31'b0, fetch_busy}, 32'd0);
    tick();

    fetch(32'h00000400, 4, 32'hDEADBEEF, 2, 1'b0);
    @(negedge clk);
    chk("flush_instr", instr_out, 32'hFE010113);
    tick();
    fetch(32'h00000500, 2, 32'h00A00513, -1, 1'b1);
    @(negedge clk);
    chk("post_flush_instr", instr_out, 32'h00A00513);
    tick();

    fetch_start = 1'b1; fetch_addr = 32'h00000600;
    tick();
    fetch_start = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", {31'b0, mem_if.mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, mem_if.mem_req}, 32'd0);
    chk("arst_instr", instr_out, NOP);
    chk("arst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("arst_cause", {30'b0, fault_cause}, 32'd0);
    chk("arst_busy", {31'b0, fetch_busy}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_busy", {31'b0, fetch_busy}, 32'd0);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
